// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: elastic pipeline register with a valid/ready handshake on
// both sides and a two-entry skid buffer. The input-side ready is decoded from
// the state register alone, so a downstream stall never forms a combinational
// path back to the producer.
module pipe_skid_reg #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  pipe_clock_input,
  input  logic                  pipe_reset_input,
  input  logic [DATA_WIDTH-1:0] pipe_input_data,
  input  logic                  pipe_input_valid,
  output logic                  pipe_input_ready,
  input  logic                  pipe_input_flush,
  output logic [DATA_WIDTH-1:0] pipe_output_data,
  output logic                  pipe_output_valid,
  input  logic                  pipe_output_ready,
  output logic [1:0]            pipe_output_count
);

  // Occupancy states: EMPTY holds nothing, BUSY holds main, FULL holds main+skid.
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_BUSY  = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  logic [1:0]            r_state;
  logic [DATA_WIDTH-1:0] r_main;
  logic [DATA_WIDTH-1:0] r_skid;

  logic [1:0] w_state_next;
  logic       w_in_fire;
  logic       w_out_fire;
  logic       w_load_main_in;
  logic       w_load_main_skid;
  logic       w_load_skid;

  // Handshake outputs come straight from the state register.
  assign pipe_input_ready  = (r_state != ST_FULL);
  assign pipe_output_valid = (r_state != ST_EMPTY);
  assign pipe_output_data  = r_main;

  assign w_in_fire  = pipe_input_valid  & pipe_input_ready;
  assign w_out_fire = pipe_output_valid & pipe_output_ready;

  // Decode the word count from the occupancy state.
  always_comb begin
    pipe_output_count = 2'd0;
    case (r_state)
      ST_BUSY: pipe_output_count = 2'd1;
      ST_FULL: pipe_output_count = 2'd2;
      default: pipe_output_count = 2'd0;
    endcase
  end

  // Next-state and data-load decisions; flush overrides every transition.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    w_state_next     = r_state;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    if (pipe_input_flush) begin
      w_state_next = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_in_fire) begin
            w_state_next   = ST_BUSY;
            w_load_main_in = 1'b1;
          end
        end
        ST_BUSY: begin
          if (w_in_fire && w_out_fire) begin
            w_load_main_in = 1'b1;
          end else if (w_in_fire) begin
            w_state_next = ST_FULL;
            w_load_skid  = 1'b1;
          end else if (w_out_fire) begin
            w_state_next = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (w_out_fire) begin
            w_state_next     = ST_BUSY;
            w_load_main_skid = 1'b1;
          end
        end
        default: w_state_next = ST_EMPTY;
      endcase
    end
  end

  // Occupancy state register.
  always_ff @(posedge pipe_clock_input or negedge pipe_reset_input) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!pipe_reset_input) r_state <= ST_EMPTY;
    else                   r_state <= w_state_next;
  end

  // Main register: loads from the producer or drains the skid entry.
  always_ff @(posedge pipe_clock_input or negedge pipe_reset_input) begin
    // NOTE: data registers are reset too, because the output data is required
    // to read zero while reset is asserted.
    if (!pipe_reset_input)     r_main <= '0;
    else if (w_load_main_in)   r_main <= pipe_input_data;
    else if (w_load_main_skid) r_main <= r_skid;
  end

  // Skid register: catches the one word accepted while the consumer stalls.
  always_ff @(posedge pipe_clock_input or negedge pipe_reset_input) begin
    if (!pipe_reset_input) r_skid <= '0;
    else if (w_load_skid)  r_skid <= pipe_input_data;
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Testbench for pipe_skid_reg: directed scenarios plus a randomized run
// checked against a two-deep queue model of the block.
module tb_pipe_skid_reg;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic         flush;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic [1:0]   out_count;

  int errors = 0;
  int checks = 0;

  pipe_skid_reg #(.DATA_WIDTH(W)) dut (
    .pipe_clock_input (clk),
    .pipe_reset_input (rst_n),
    .pipe_input_data  (in_data),
    .pipe_input_valid (in_valid),
    .pipe_input_ready (in_ready),
    .pipe_input_flush (flush),
    .pipe_output_data (out_data),
    .pipe_output_valid(out_valid),
    .pipe_output_ready(out_ready),
    .pipe_output_count(out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_data = '0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    #2;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_count !== 2'd0 || out_data !== '0) begin
      errors++;
      $display("FAIL reset: valid=%b ready=%b count=%0d data=%h, required 0 1 0 0",
               out_valid, in_ready, out_count, out_data);
    end
    cycle();
    rst_n = 1'b1;
    cycle();
    checks++;
    if (out_valid !== 1'b0 || out_count !== 2'd0) begin
      errors++;
      $display("FAIL reset_release: valid=%b count=%0d, required 0 0", out_valid, out_count);
    end
  endtask

  task automatic test_stream();
    logic [W-1:0] want;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_data = W'(i);
      want    = W'(i);
      cycle();
      checks++;
      if (out_valid !== 1'b1 || out_data !== want || out_count !== 2'd1 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL stream[%0d]: valid=%b data=%h count=%0d ready=%b, required 1 %h 1 1",
                 i, out_valid, out_data, out_count, in_ready, want);
      end
    end
    in_valid = 1'b0;
    cycle();
    checks++;
    if (out_valid !== 1'b0 || out_count !== 2'd0) begin
      errors++;
      $display("FAIL stream_drain: valid=%b count=%0d, required 0 0", out_valid, out_count);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hA;
    cycle();
    checks++;
    if (out_count !== 2'd1 || in_ready !== 1'b1 || out_data !== 32'hA) begin
      errors++;
      $display("FAIL bp_first: count=%0d ready=%b data=%h, required 1 1 a", out_count, in_ready, out_data);
    end
    in_data = 32'hB;
    cycle();
    checks++;
    if (out_count !== 2'd2 || in_ready !== 1'b0 || out_data !== 32'hA) begin
      errors++;
      $display("FAIL bp_full: count=%0d ready=%b data=%h, required 2 0 a", out_count, in_ready, out_data);
    end
    in_data = 32'hC;   // offered while full: must not be accepted
    cycle();
    checks++;
    if (out_count !== 2'd2 || out_data !== 32'hA || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_hold: count=%0d data=%h valid=%b, required 2 a 1", out_count, out_data, out_valid);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cycle();
    checks++;
    if (out_data !== 32'hB || out_count !== 2'd1 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_drain1: data=%h count=%0d ready=%b, required b 1 1", out_data, out_count, in_ready);
    end
    cycle();
    checks++;
    if (out_valid !== 1'b0 || out_count !== 2'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_drain2: valid=%b count=%0d ready=%b, required 0 0 1", out_valid, out_count, in_ready);
    end
  endtask

  task automatic test_simultaneous();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h10;
    cycle();
    in_data   = 32'h11;
    out_ready = 1'b1;
    cycle();
    checks++;
    if (out_data !== 32'h11 || out_count !== 2'd1 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL simul: data=%h count=%0d valid=%b, required 11 1 1", out_data, out_count, out_valid);
    end
    in_valid = 1'b0;
    cycle();
    checks++;
    if (out_valid !== 1'b0 || out_count !== 2'd0) begin
      errors++;
      $display("FAIL simul_drain: valid=%b count=%0d, required 0 0 (skid must be unused)",
               out_valid, out_count);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h20;
    cycle();
    in_data   = 32'h21;
    cycle();
    in_data   = 32'h22;
    flush     = 1'b1;
    out_ready = 1'b1;
    cycle();
    checks++;
    if (out_valid !== 1'b0 || out_count !== 2'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush: valid=%b count=%0d ready=%b, required 0 0 1", out_valid, out_count, in_ready);
    end
    // A word offered during flush from EMPTY is also discarded.
    cycle();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_in_empty: valid=%b, required 0", out_valid);
    end
    flush    = 1'b0;
    in_valid = 1'b0;
    cycle();
    checks++;
    if (out_valid !== 1'b0 || out_count !== 2'd0) begin
      errors++;
      $display("FAIL flush_after: valid=%b count=%0d, required 0 0", out_valid, out_count);
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h30;
    cycle();
    in_data   = 32'h31;
    cycle();
    in_valid  = 1'b0;
    checks++;
    if (out_count !== 2'd2) begin
      errors++;
      $display("FAIL async_setup: count=%0d, required 2", out_count);
    end
    #2 rst_n = 1'b0;   // mid-cycle, well away from the next edge
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || in_ready !== 1'b1 || out_count !== 2'd0) begin
      errors++;
      $display("FAIL async_reset: valid=%b data=%h ready=%b count=%0d, required 0 0 1 0",
               out_valid, out_data, in_ready, out_count);
    end
    cycle();
    rst_n = 1'b1;
    cycle();
    checks++;
    if (out_valid !== 1'b0 || out_count !== 2'd0) begin
      errors++;
      $display("FAIL async_release: valid=%b count=%0d, required 0 0", out_valid, out_count);
    end
  endtask

  // Randomized run against a queue model: the block is a FIFO of depth 2 that
  // accepts when it has room, delivers its oldest word, and empties on flush.
  task automatic test_random();
    logic [W-1:0] q[$];
    logic         m_in_fire;
    logic         m_out_fire;
    logic         m_ready;
    int           delivered = 0;
    for (int n = 0; n < 10000; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      #1;
      m_ready = (q.size() < 2);
      checks++;
      if (in_ready !== m_ready) begin
        errors++;
        $display("FAIL rand_ready_pre[%0d]: ready=%b, required %b", n, in_ready, m_ready);
      end
      m_in_fire  = in_valid && m_ready;
      m_out_fire = out_ready && (q.size() > 0);
      cycle();
      if (flush) begin
        q.delete();
      end else begin
        if (m_out_fire) begin
          void'(q.pop_front());
          delivered++;
        end
        if (m_in_fire) q.push_back(in_data);
      end
      checks++;
      if (out_valid !== (q.size() > 0) || out_count !== 2'(q.size()) ||
          in_ready !== (q.size() < 2) || (q.size() > 0 && out_data !== q[0])) begin
        errors++;
        $display("FAIL rand[%0d]: valid=%b count=%0d ready=%b data=%h, required count=%0d data=%h",
                 n, out_valid, out_count, in_ready, out_data, q.size(),
                 (q.size() > 0) ? q[0] : '0);
      end
    end
    checks++;
    if (delivered < 1000) begin
      errors++;
      $display("FAIL rand_traffic: delivered=%0d, required at least 1000", delivered);
    end
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_simultaneous();
    test_flush();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
